iter_mdu: RTL and testbench

// Parametrised multi-cycle multiply/divide unit with HI/LO, sitting beside the ALU in the E stage.

---
 rtl/iter_mdu_if.sv | 13 +
 rtl/iter_mdu.sv | 125 ++++++++++++
 tb/tb_iter_mdu.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/iter_mdu_if.sv
// Issue/result bus between the E-stage sequencer and the multiply/divide unit.
interface iter_mdu_if #(parameter int WIDTH = 32) ();
  logic [WIDTH-1:0] num_a;
  logic [WIDTH-1:0] num_b;
  logic [3:0]       mdu_op;
  logic             req;
  logic             busy;
  logic [WIDTH-1:0] mdu_out;
  logic             done;

  modport master (output num_a, num_b, mdu_op, req, input busy, mdu_out, done);
  modport slave  (input num_a, num_b, mdu_op, req, output busy, mdu_out, done);
endinterface

// File: rtl/iter_mdu.sv
// Multi-cycle MDU: delayed-result multiply/accumulate plus restoring divider,
// both writing the HI/LO pair and pulsing done the cycle after.
module iter_mdu #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5
) (
  input  logic     clk,
  input  logic     reset,
  iter_mdu_if.slave bus
);
  localparam int CMAX = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV_ITER, DIV_FIX} state_e;

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic [1:0]         acc_q;      // [0] add product, [1] subtract product
  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH-1:0]   rem_q, quo_q, dvs_q;
  logic               qneg_q, rneg_q;
  logic               done_q;

  logic               start_op, is_div, sgn, issue, a_neg, b_neg;
  logic [WIDTH-1:0]   a_abs, b_abs, quo_fix, rem_fix;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod_c, hilo, mul_wr;
  logic [WIDTH:0]     sh, diff;
  logic               borrow;

  assign start_op = (bus.mdu_op[3:2] == 2'b00) | (bus.mdu_op[3:2] == 2'b10);
  assign is_div   = (bus.mdu_op[3:1] == 3'b001);
  assign sgn      = ~bus.mdu_op[0];
  assign issue    = (state_q == IDLE) & ~bus.req & start_op;

  assign a_neg  = sgn & bus.num_a[WIDTH-1];
  assign b_neg  = sgn & bus.num_b[WIDTH-1];
  assign a_abs  = a_neg ? -bus.num_a : bus.num_a;
  assign b_abs  = b_neg ? -bus.num_b : bus.num_b;
  // Sign-extending to 2*WIDTH makes one truncated multiply serve both signednesses.
  assign ext_a  = {{WIDTH{a_neg}}, bus.num_a};
  assign ext_b  = {{WIDTH{b_neg}}, bus.num_b};
  assign prod_c = ext_a * ext_b;

  assign hilo   = {hi_q, lo_q};
  assign mul_wr = acc_q[1] ? (hilo - prod_q) :
                  acc_q[0] ? (hilo + prod_q) : prod_q;

  // Restoring step: bring in the next dividend bit, keep the trial difference if no borrow.
  assign sh     = {rem_q, quo_q[WIDTH-1]};
  assign diff   = sh - {1'b0, dvs_q};
  assign borrow = diff[WIDTH];

  assign quo_fix = qneg_q ? -quo_q : quo_q;
  assign rem_fix = rneg_q ? -rem_q : rem_q;

  assign bus.mdu_out = (bus.mdu_op == 4'd5) ? hi_q : lo_q;
  assign bus.busy    = (state_q != IDLE) | start_op;
  assign bus.done    = done_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (issue) begin
            if (is_div) begin
              state_q <= DIV_ITER;
              cnt_q   <= CW'(WIDTH-1);
              rem_q   <= '0;
              quo_q   <= a_abs;
              dvs_q   <= b_abs;
              qneg_q  <= a_neg ^ b_neg;
              rneg_q  <= a_neg;
            end else begin
              state_q <= MUL;
              cnt_q   <= CW'(MUL_CYCLES-1);
              prod_q  <= prod_c;
              acc_q   <= bus.mdu_op[3] ? {bus.mdu_op[1], ~bus.mdu_op[1]} : 2'b00;
            end
          end else if (!bus.req && bus.mdu_op == 4'd6) begin
            lo_q <= bus.num_a;
          end else if (!bus.req && bus.mdu_op == 4'd7) begin
            hi_q <= bus.num_a;
          end
        end
        MUL: begin
          if (cnt_q == '0) begin
            {hi_q, lo_q} <= mul_wr;
            done_q       <= 1'b1;
            state_q      <= IDLE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        DIV_ITER: begin
          rem_q <= borrow ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
          quo_q <= {quo_q[WIDTH-2:0], ~borrow};
          if (cnt_q == '0) state_q <= DIV_FIX;
          else             cnt_q   <= cnt_q - CW'(1);
        end
        DIV_FIX: begin
          lo_q    <= quo_fix;
          hi_q    <= rem_fix;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_iter_mdu.sv
// Random + directed bench for iter_mdu against a cycle-level behavioural model.
module tb_iter_mdu;
  localparam int W  = 32;
  localparam int MC = 5;

  logic clk = 1'b0;
  logic reset;
  iter_mdu_if #(.WIDTH(W)) bus ();
  iter_mdu #(.WIDTH(W), .MUL_CYCLES(MC)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic bit is_start(input logic [3:0] op);
    return (op <= 4'd3) || (op >= 4'd8 && op <= 4'd11);
  endfunction

  // Result of an op as plain arithmetic; hilo is the pair at the write edge.
  function automatic logic [63:0] model_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                            input logic [63:0] hl);
    logic [63:0] p;
    logic [31:0] q, r;
    case (op)
      4'd2: begin
        if (b == 0) begin q = ($signed(a) < 0) ? 32'd1 : 32'hFFFFFFFF; r = a; end
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin q = a; r = 0; end
        else begin q = $signed(a) / $signed(b); r = $signed(a) % $signed(b); end
        return {r, q};
      end
      4'd3: begin
        if (b == 0) begin q = 32'hFFFFFFFF; r = a; end
        else begin q = a / b; r = a % b; end
        return {r, q};
      end
      default: begin
        if (!op[0]) p = longint'($signed(a)) * longint'($signed(b));
        else        p = {32'b0, a} * {32'b0, b};
        if (op == 4'd8 || op == 4'd9)        return hl + p;
        else if (op == 4'd10 || op == 4'd11) return hl - p;
        else                                 return p;
      end
    endcase
  endfunction

  logic [31:0] m_hi, m_lo, m_a, m_b;
  logic [3:0]  m_op;
  logic        m_pend, m_done;
  int          m_rem;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_hi <= 0; m_lo <= 0; m_pend <= 0; m_rem <= 0; m_done <= 0;
      m_op <= 0; m_a <= 0; m_b <= 0;
    end else begin
      m_done <= 0;
      if (m_pend) begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          {m_hi, m_lo} <= model_res(m_op, m_a, m_b, {m_hi, m_lo});
          m_done <= 1;
          m_pend <= 0;
        end
      end else if (!bus.req) begin
        if (is_start(bus.mdu_op)) begin
          m_pend <= 1;
          m_rem  <= (bus.mdu_op == 4'd2 || bus.mdu_op == 4'd3) ? W + 1 : MC;
          m_op   <= bus.mdu_op; m_a <= bus.num_a; m_b <= bus.num_b;
        end else if (bus.mdu_op == 4'd6) m_lo <= bus.num_a;
        else if (bus.mdu_op == 4'd7)     m_hi <= bus.num_a;
      end
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      chk("busy", bus.busy, m_pend | is_start(bus.mdu_op));
      chk("mdu_out", bus.mdu_out, (bus.mdu_op == 4'd5) ? m_hi : m_lo);
      chk("done", bus.done, m_done);
    end
  end

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic r);
    bus.mdu_op = op; bus.num_a = a; bus.num_b = b; bus.req = r;
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int bc, output int dc);
    bit fin = 0;
    @(negedge clk); drive(op, a, b, 0); #1;
    bc = bus.busy ? 1 : 0; dc = 0;
    for (int i = 0; i < 100 && !fin; i++) begin
      @(negedge clk); drive(4'd12, 0, 0, 0); #1;
      if (bus.done) dc++;
      if (!bus.busy) fin = 1; else bc++;
    end
    if (!fin) begin
      checks++; failures++;
      $display("FAIL run_op_timeout: op %0d still busy after 100 cycles, required idle", op);
    end
    @(negedge clk); #1;
    if (bus.done) dc++;
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    @(negedge clk); drive(4'd4, 0, 0, 0); #2; lo = bus.mdu_out;
    @(negedge clk); drive(4'd5, 0, 0, 0); #2; hi = bus.mdu_out;
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] v);
    @(negedge clk); drive(op, v, 0, 0);
    @(negedge clk); drive(4'd12, 0, 0, 0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  int bc, dc;
  logic [31:0] hi, lo;

  initial begin
    reset = 0;
    drive(4'd12, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_lo", bus.mdu_out, 0);
    chk("rst_done", bus.done, 0);
    @(negedge clk); reset = 1;

    run_op(4'd0, 32'hFFFFFFFD, 32'd5, bc, dc);
    chk("mult_busy_cycles", bc, 6);
    chk("mult_done_pulses", dc, 1);
    read_hilo(hi, lo);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFF1);

    run_op(4'd2, 32'hFFFFFFF9, 32'd2, bc, dc);
    chk("div_busy_cycles", bc, 34);
    chk("div_done_pulses", dc, 1);
    read_hilo(hi, lo);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);

    run_op(4'd2, 32'h80000000, 32'hFFFFFFFF, bc, dc);
    read_hilo(hi, lo);
    chk("divovf_lo", lo, 32'h80000000);
    chk("divovf_hi", hi, 32'h0);

    run_op(4'd3, 32'h1234, 32'h0, bc, dc);
    read_hilo(hi, lo);
    chk("divu0_lo", lo, 32'hFFFFFFFF);
    chk("divu0_hi", hi, 32'h1234);

    mt(4'd7, 32'd1);
    mt(4'd6, 32'd0);
    run_op(4'd11, 32'd1, 32'd1, bc, dc);
    read_hilo(hi, lo);
    chk("msubu_hi", hi, 32'h0);
    chk("msubu_lo", lo, 32'hFFFFFFFF);
    run_op(4'd8, 32'd1, 32'd1, bc, dc);
    read_hilo(hi, lo);
    chk("madd_hi", hi, 32'h1);
    chk("madd_lo", lo, 32'h0);

    // Interrupt request blocks both issue and MT.
    @(negedge clk); drive(4'd2, 32'd9, 32'd3, 1); #1;
    chk("req_div_busy_comb", bus.busy, 1);
    @(negedge clk); drive(4'd12, 0, 0, 0); #1;
    chk("req_div_busy_after", bus.busy, 0);
    @(negedge clk); drive(4'd6, 32'h55, 0, 1);
    @(negedge clk); drive(4'd12, 0, 0, 0);
    read_hilo(hi, lo);
    chk("req_mtlo_lo", lo, 32'h0);

    // Asynchronous reset in the middle of a divide.
    @(negedge clk); drive(4'd2, 32'd100, 32'd3, 0);
    @(negedge clk); drive(4'd12, 0, 0, 0);
    repeat (7) @(negedge clk);
    #2 reset = 0;
    #1;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_lo", bus.mdu_out, 0);
    @(negedge clk); drive(4'd5, 0, 0, 0); #1;
    chk("midrst_hi", bus.mdu_out, 0);
    @(negedge clk); reset = 1; drive(4'd12, 0, 0, 0);
    run_op(4'd1, 32'd3, 32'd4, bc, dc);
    read_hilo(hi, lo);
    chk("multu_after_rst_lo", lo, 32'd12);
    chk("multu_after_rst_hi", hi, 32'd0);

    // Random phase: the every-cycle compare does the checking.
    repeat (3000) begin
      @(negedge clk);
      drive(4'($urandom_range(0, 15)), pick(), pick(), ($urandom_range(0, 3) == 0));
    end
    @(negedge clk); drive(4'd12, 0, 0, 0);
    repeat (40) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
